// File: rtl/seg_scan_ctrl.sv
// Scan controller for an N-digit common-anode 7-segment display that shares one
// external hex decoder across digits; displayed values swap in only at frame end.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DWELL    = 50000,
  parameter int unsigned BLANK    = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_mask,
  output logic [3:0]              dec_nibble,
  input  logic [6:0]              dec_seg,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     an_n,
  output logic                    frame_done
);

  localparam int unsigned T_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned IW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DW    = 4 * N_DIGITS;

  localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK - 1);
  localparam logic [TW-1:0] T_DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] T_DWELL_PRE  = TW'((DWELL > 1) ? (DWELL - 2) : 0);
  localparam logic [IW-1:0] I_LAST       = IW'(N_DIGITS - 1);
  localparam logic          DWELL_ONE    = (DWELL == 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  logic [1:0]          r_state,      w_state_nxt;
  logic [TW-1:0]       r_timer,      w_timer_nxt;
  logic [IW-1:0]       r_idx,        w_idx_nxt;
  logic [DW-1:0]       r_stg_digits, w_stg_digits_nxt;
  logic [N_DIGITS-1:0] r_stg_dp,     w_stg_dp_nxt;
  logic [N_DIGITS-1:0] r_stg_mask,   w_stg_mask_nxt;
  logic [DW-1:0]       r_act_digits, w_act_digits_nxt;
  logic [N_DIGITS-1:0] r_act_dp,     w_act_dp_nxt;
  logic [N_DIGITS-1:0] r_act_mask,   w_act_mask_nxt;
  logic                r_pend,       w_pend_nxt;
  logic [3:0]          r_dec_nibble, w_dec_nibble_nxt;
  logic [6:0]          r_seg_n,      w_seg_n_nxt;
  logic                r_dp_n,       w_dp_n_nxt;
  logic [N_DIGITS-1:0] r_an_n,       w_an_n_nxt;
  logic                r_frame_done, w_frame_done_nxt;

  logic [N_DIGITS-1:0] w_cur_an;
  logic                w_cur_dp;
  logic                w_swap;

  // Anode pattern and decimal point for the digit currently being scanned.
  always_comb begin
    w_cur_an = '1;
    w_cur_dp = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (IW'(i) == r_idx) begin
        w_cur_an[i] = r_act_mask[i];
        w_cur_dp    = r_act_dp[i];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_idx_nxt        = r_idx;
    w_stg_digits_nxt = r_stg_digits;
    w_stg_dp_nxt     = r_stg_dp;
    w_stg_mask_nxt   = r_stg_mask;
    w_act_digits_nxt = r_act_digits;
    w_act_dp_nxt     = r_act_dp;
    w_act_mask_nxt   = r_act_mask;
    w_pend_nxt       = r_pend;
    w_seg_n_nxt      = r_seg_n;
    w_dp_n_nxt       = r_dp_n;
    w_an_n_nxt       = '1;
    w_frame_done_nxt = 1'b0;
    w_swap           = 1'b0;

    if (load) begin
      w_stg_digits_nxt = digits_in;
      w_stg_dp_nxt     = dp_in;
      w_stg_mask_nxt   = blank_mask;
      w_pend_nxt       = 1'b1;
    end

    if (!en) begin
      w_state_nxt = S_IDLE;
      w_timer_nxt = '0;
      w_idx_nxt   = '0;
      w_seg_n_nxt = 7'h7F;
      w_dp_n_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
        end
        S_BLANK: begin
          if (r_timer == T_BLANK_LAST) begin
            w_state_nxt      = S_SHOW;
            w_timer_nxt      = '0;
            w_seg_n_nxt      = ~dec_seg;
            w_dp_n_nxt       = ~w_cur_dp;
            w_an_n_nxt       = w_cur_an;
            w_frame_done_nxt = DWELL_ONE && (r_idx == I_LAST);
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        S_SHOW: begin
          if (r_timer == T_DWELL_LAST) begin
            w_state_nxt = S_BLANK;
            w_timer_nxt = '0;
            if (r_idx == I_LAST) begin
              w_idx_nxt = '0;
              w_swap    = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end else begin
            w_timer_nxt      = r_timer + TW'(1);
            w_an_n_nxt       = w_cur_an;
            // Look ahead so the pulse lands on the last lit cycle of the frame.
            w_frame_done_nxt = (r_timer == T_DWELL_PRE) && (r_idx == I_LAST);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end

    // A load coinciding with the swap bypasses staging.
    if (w_swap) begin
      if (load) begin
        w_act_digits_nxt = digits_in;
        w_act_dp_nxt     = dp_in;
        w_act_mask_nxt   = blank_mask;
      end else if (r_pend) begin
        w_act_digits_nxt = r_stg_digits;
        w_act_dp_nxt     = r_stg_dp;
        w_act_mask_nxt   = r_stg_mask;
      end
      w_pend_nxt = 1'b0;
    end
  end

  // Present the nibble of the upcoming digit so the decoder settles during blanking.
  always_comb begin
    w_dec_nibble_nxt = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (IW'(i) == w_idx_nxt) begin
        w_dec_nibble_nxt = w_act_digits_nxt[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_idx        <= '0;
      r_stg_digits <= '0;
      r_stg_dp     <= '0;
      r_stg_mask   <= '0;
      r_act_digits <= '0;
      r_act_dp     <= '0;
      r_act_mask   <= '0;
      r_pend       <= 1'b0;
      r_dec_nibble <= '0;
      r_seg_n      <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_idx        <= w_idx_nxt;
      r_stg_digits <= w_stg_digits_nxt;
      r_stg_dp     <= w_stg_dp_nxt;
      r_stg_mask   <= w_stg_mask_nxt;
      r_act_digits <= w_act_digits_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_act_mask   <= w_act_mask_nxt;
      r_pend       <= w_pend_nxt;
      r_dec_nibble <= w_dec_nibble_nxt;
      r_seg_n      <= w_seg_n_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_an_n       <= w_an_n_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign dec_nibble = r_dec_nibble;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: expected lit-digit windows are queued as stimulus is
// applied and compared as each anode-low window closes.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  dec_nibble;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
    int         gap;
  } win_t;

  win_t sb_q[$];
  win_t cur;
  bit   in_win    = 1'b0;
  int   blank_run = 0;
  int   n_cmp     = 0;
  int   n_err     = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.N_DIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .dec_nibble (dec_nibble),
    .dec_seg    (dec_seg),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  // Stand-in for the shared hex decoder, {g..a} active-high.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  assign dec_seg = hex7(dec_nibble);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue the windows one frame should produce; gap 0 means not checked.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] mask,
                            input bit first_free, input int n_win, input int last_len);
    win_t e;
    int   skipped = 0;
    logic [3:0] dig;
    for (int i = 0; i < n_win; i++) begin
      if (mask[i]) begin
        skipped++;
        continue;
      end
      dig      = d[4*i +: 4];
      e.an     = 4'hF;
      e.an[i]  = 1'b0;
      e.seg    = ~hex7(dig);
      e.dp     = ~dp[i];
      e.len    = (i == n_win - 1) ? last_len : DW;
      e.gap    = (i == 0 && first_free) ? 0 : BL + skipped * (BL + DW);
      skipped  = 0;
      sb_q.push_back(e);
    end
  endtask

  task automatic close_win();
    win_t e;
    if (sb_q.size() == 0) begin
      chk("sb_expected_window", 32'(sb_q.size()), 32'(1));
    end else begin
      e = sb_q.pop_front();
      chk("win_an",  32'(cur.an),  32'(e.an));
      chk("win_seg", 32'(cur.seg), 32'(e.seg));
      chk("win_dp",  32'(cur.dp),  32'(e.dp));
      chk("win_len", 32'(cur.len), 32'(e.len));
      if (e.gap != 0) chk("win_gap", 32'(cur.gap), 32'(e.gap));
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and track windows.
  task automatic step();
    int zeros;
    @(posedge clk);
    #1;
    zeros = 0;
    for (int i = 0; i < ND; i++) if (an_n[i] == 1'b0) zeros++;
    chk("an_single_low", 32'(zeros <= 1), 32'(1));
    if (an_n != 4'hF) begin
      if (!in_win) begin
        in_win  = 1'b1;
        cur.an  = an_n;
        cur.seg = seg_n;
        cur.dp  = dp_n;
        cur.len = 1;
        cur.gap = blank_run;
      end else begin
        chk("win_stable", 32'({an_n, seg_n, dp_n}), 32'({cur.an, cur.seg, cur.dp}));
        cur.len++;
      end
      blank_run = 0;
    end else begin
      if (in_win) begin
        in_win = 1'b0;
        close_win();
      end
      blank_run++;
    end
  endtask

  task automatic wait_an(input logic [3:0] val, input int budget);
    int k = 0;
    while (an_n !== val && k < budget) begin
      step();
      k++;
    end
    chk("wait_an", 32'(an_n), 32'(val));
  endtask

  task automatic wait_fd(input int budget);
    int k = 0;
    while (frame_done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("wait_frame_done", 32'(frame_done), 32'(1));
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"},  32'(an_n),       32'(4'hF));
    chk({tag, "_seg"}, 32'(seg_n),      32'(7'h7F));
    chk({tag, "_dp"},  32'(dp_n),       32'(1));
    chk({tag, "_fd"},  32'(frame_done), 32'(0));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0;
    digits_in = '0; dp_in = '0; blank_mask = '0;

    repeat (3) begin
      step();
      chk_dark("reset");
      chk("reset_nibble", 32'(dec_nibble), 32'(0));
    end
    rst = 1'b0;

    // Load while disabled: staged, not shown until the first frame boundary.
    digits_in = 16'h3210; load = 1'b1;
    step();
    load = 1'b0; digits_in = '0;
    step();
    chk_dark("idle_after_load");

    en = 1'b1;
    push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 4, DW);
    push_frame(16'h3210, 4'h0, 4'h0, 1'b0, 4, DW);
    for (int k = 1; k <= 48; k++) begin
      step();
      chk("frame_done_timing", 32'(frame_done), 32'(k == 24 || k == 48));
      if (k == 2) chk("an_before_first", 32'(an_n), 32'(4'hF));
      if (k == 3) chk("an_first_low", 32'(an_n), 32'(4'hE));
    end

    // Two loads mid-frame: the last one is shown after the next swap.
    push_frame(16'h3210, 4'h0, 4'h0, 1'b0, 4, DW);
    step();
    step();
    digits_in = 16'h1111; dp_in = 4'h0; blank_mask = 4'h0; load = 1'b1;
    step();
    digits_in = 16'h7A5C; dp_in = 4'b0001; blank_mask = 4'b0100;
    push_frame(16'h7A5C, 4'b0001, 4'b0100, 1'b0, 4, DW);
    step();
    load = 1'b0; digits_in = '0; dp_in = '0; blank_mask = '0;
    wait_fd(40);
    step();
    wait_fd(40);

    // Load in the frame_done cycle goes live immediately.
    digits_in = 16'hFFFF; load = 1'b1;
    push_frame(16'hFFFF, 4'h0, 4'h0, 1'b0, 3, 2);
    step();
    load = 1'b0; digits_in = '0;

    // Drop enable during the second lit cycle of digit 2.
    wait_an(4'hB, 40);
    step();
    en = 1'b0;
    step();
    chk_dark("en_drop");
    step();
    chk_dark("en_low");

    // Re-enable restarts at digit 0; reset during digit 1.
    en = 1'b1;
    push_frame(16'hFFFF, 4'h0, 4'h0, 1'b1, 2, 1);
    step();
    step();
    chk("reenable_an_blank", 32'(an_n), 32'(4'hF));
    step();
    chk("reenable_digit0", 32'(an_n), 32'(4'hE));
    wait_an(4'hD, 20);
    rst = 1'b1;
    step();
    chk_dark("mid_rst");
    chk("mid_rst_nibble", 32'(dec_nibble), 32'(0));
    rst = 1'b0;

    // After reset the active set is cleared, so zeros are displayed.
    push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 4, DW);
    wait_fd(40);
    en = 1'b0;
    step();
    chk_dark("final_dark");
    step();
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one instance of the team's combinational hex-to-7-segment decoder across all digits: presents one nibble at a time, registers the returned segment pattern, and drives digit anodes.
- Applies a blanking interval between digits to prevent ghosting.
- Double-buffers displayed values so updates take effect only at frame boundaries.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- DWELL, 50000, clock cycles each digit is lit (>=1).
- BLANK, 500, clock cycles all anodes are off before each digit (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  scan enable; 0 forces display dark and scanner idle.
- load  in  1  one-cycle strobe: capture digits_in/dp_in/blank_mask into staging.
- digits_in  in  4*N_DIGITS  hex nibbles; digit i = bits [4i+3:4i].
- dp_in  in  N_DIGITS  decimal point per digit, active-high.
- blank_mask  in  N_DIGITS  1 = digit i never lit.
- dec_nibble  out  4  nibble presented to the shared decoder.
- dec_seg  in  7  decoder result {g..a}, active-high, combinational from dec_nibble.
- seg_n  out  7  segment drive {g..a}, active-low.
- dp_n  out  1  decimal point drive, active-low.
- an_n  out  N_DIGITS  anode enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Clock clk; reset rst synchronous, active-high.
- Reset values: an_n all 1, seg_n 7'h7F, dp_n 1, dec_nibble 0, frame_done 0, digit index 0, state IDLE, staging/active registers 0, load-pending 0.
- Register sets: staging (captured on load) and active (drives scan). load sets pending.
- FSM states:
  - IDLE: an_n all 1. Enters BLANK for digit 0 on the cycle after en=1; timer cleared.
  - BLANK: timer counts BLANK cycles. dec_nibble = active nibble of current index. an_n all 1. On the last BLANK cycle, register seg_n <= ~dec_seg and dp_n <= ~active_dp[idx]; go to SHOW.
  - SHOW: timer counts DWELL cycles. an_n[idx]=0 unless active blank_mask[idx]=1, in which case all 1. seg_n/dp_n hold.
    - Last SHOW cycle, idx<N-1: idx++, go to BLANK.
    - Last SHOW cycle, idx=N-1: idx wraps to 0, frame_done=1 for that cycle, frame swap, go to BLANK.
- Frame swap rules:
  - If load=1 in the swap cycle, active <= live inputs.
  - Else if pending, active <= staging.
  - Pending cleared in either case.
  - Otherwise active unchanged.
- Timing: frame length = N_DIGITS*(BLANK+DWELL) cycles; first anode low at cycle BLANK+1 after en rises (IDLE->BLANK costs 1 cycle).
- Anode and segment outputs are registered; no combinational path from inputs to outputs.
- en deasserted in any state: next cycle an_n all 1, seg_n 7'h7F, dp_n 1, state IDLE, idx 0, timer 0. Active/staging/pending retained.
- load while en=0: staging captured. First swap occurs at the first frame end after re-enable.
- Multiple loads in one frame: last one wins.
- rst mid-frame: all state returns to reset values on the next edge, regardless of en or load.
- Counters sized $clog2(max(DWELL,BLANK)+1); idx sized $clog2(N_DIGITS) (min 1 bit).

Test Plan (N_DIGITS=4, DWELL=4, BLANK=2, frame = 24 cycles):
- rst=1 for 3 cycles, en=0 -> an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0 throughout.
- load digits_in=16'h3210 while en=0, then en=1 -> first frame shows old value 0000 (an_n 4'hE/D/B/7 in turn, seg_n=~7'h3F). frame_done at cycle 24 after en. Second frame: digit0 seg_n=~7'h3F, digit1 ~7'h06, digit2 ~7'h5B, digit3 ~7'h4F.
- Scan check: between consecutive anode-low windows, exactly 2 cycles of an_n=4'hF. Each window exactly 4 cycles. an_n never has more than one 0 bit.
- blank_mask=4'b0100 and dp_in=4'b0001 loaded -> after next swap, an_n never equals 4'hB; dp_n=0 only during digit 0 windows.
- load asserted exactly in the frame_done cycle with digits_in=16'hFFFF -> next frame displays F on all digits (seg_n=~7'h71).
- en dropped mid-SHOW of digit 2 -> next cycle an_n=4'hF and seg_n=7'h7F. Re-enable restarts at digit 0. rst pulsed mid-frame -> all outputs at reset values after the next edge.
